// File: rtl/dm_responder.sv
// dm_responder: data-memory target of the MIPS core m_data_* port, byte-enabled writes, combinational reads.
// Define DM_TRACE_EN to build the first-word-fall-through store trace queue; otherwise trace outputs are tied to 0.
module dm_responder #(
    parameter int WORDS       = 3072,
    parameter int TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow,
    output logic        addr_err
);
    localparam int IW = $clog2(WORDS);

    logic [31:0]   mem [WORDS];
    logic [29:0]   word_idx;
    logic [IW-1:0] mem_idx;
    logic          in_range;
    logic          store_req;
    logic          store_ok;
    logic          store_bad;
    logic [31:0]   cur_word;
    logic [31:0]   merged;
    logic          unused_addr_lsb;

    assign word_idx        = m_data_addr[31:2];
    assign in_range        = word_idx < 30'(WORDS);
    assign mem_idx         = word_idx[IW-1:0];
    assign store_req       = |m_data_byteen;
    assign store_ok        = store_req && in_range;
    assign store_bad       = store_req && !in_range;
    assign cur_word        = in_range ? mem[mem_idx] : 32'h0;
    assign m_data_rdata    = cur_word;
    assign unused_addr_lsb = ^m_data_addr[1:0];

    always_comb begin
        merged = cur_word;
        for (int k = 0; k < 4; k++) begin
            if (m_data_byteen[k]) merged[8*k +: 8] = m_data_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
            addr_err <= 1'b0;
        end else begin
            if (store_ok) mem[mem_idx] <= merged;
            if (store_bad) addr_err <= 1'b1;
        end
    end

`ifdef DM_TRACE_EN
    localparam int PW = $clog2(TRACE_DEPTH);

    logic [31:0] q_pc   [TRACE_DEPTH];
    logic [31:0] q_addr [TRACE_DEPTH];
    logic [31:0] q_data [TRACE_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic [31:0]   push_addr;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          bypass;

    assign push_addr  = {word_idx, 2'b00};
    assign full       = count == (PW+1)'(TRACE_DEPTH);
    assign pop        = trace_valid && trace_ready;
    assign do_push    = store_ok && (!full || pop);
    assign rd_next    = rd_ptr + PW'(pop);
    assign count_next = count + (PW+1)'(do_push) - (PW+1)'(pop);
    // The new record becomes the head directly when nothing older remains after this cycle's pop.
    assign bypass     = do_push && ((count - (PW+1)'(pop)) == '0);

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            q_pc[wr_ptr]   <= m_inst_addr;
            q_addr[wr_ptr] <= push_addr;
            q_data[wr_ptr] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            trace_valid    <= 1'b0;
            trace_pc       <= 32'h0;
            trace_addr     <= 32'h0;
            trace_data     <= 32'h0;
            trace_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr      <= rd_next;
            count       <= count_next;
            trace_valid <= count_next != '0;
            if (bypass) begin
                trace_pc   <= m_inst_addr;
                trace_addr <= push_addr;
                trace_data <= merged;
            end else if (count_next != '0) begin
                trace_pc   <= q_pc[rd_next];
                trace_addr <= q_addr[rd_next];
                trace_data <= q_data[rd_next];
            end
            if (store_ok && full && !pop) trace_overflow <= 1'b1;
        end
    end
`else
    logic unused_trace;

    assign unused_trace   = ^{trace_ready, m_inst_addr};
    assign trace_valid    = 1'b0;
    assign trace_pc       = 32'h0;
    assign trace_addr     = 32'h0;
    assign trace_data     = 32'h0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: vector table for read/write paths plus hand sequences for
// out-of-range stores, reset, and trace queue overflow / full push-pop (when DM_TRACE_EN is defined).
module tb_dm_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        trace_overflow;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    dm_responder #(.WORDS(3072), .TRACE_DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .m_data_addr    (m_data_addr),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .m_inst_addr    (m_inst_addr),
        .m_data_rdata   (m_data_rdata),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow),
        .addr_err       (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] pc;
        logic [31:0] exp_rd;
        logic        exp_tv;
        logic [31:0] exp_tpc;
        logic [31:0] exp_taddr;
        logic [31:0] exp_tdata;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] pc);
        m_data_addr   = a;
        m_data_wdata  = wd;
        m_data_byteen = be;
        m_inst_addr   = pc;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(a, 32'h0, 4'b0000, 32'h0);
        #1;
        check(name, m_data_rdata, exp);
    endtask

    function automatic logic [31:0] rec_addr(input int i);
        return 32'h100 + 32'(i) * 4;
    endfunction
    function automatic logic [31:0] rec_data(input int i);
        return 32'hC0DE0000 + 32'(i);
    endfunction
    function automatic logic [31:0] rec_pc(input int i);
        return 32'h00400500 + 32'(i) * 4;
    endfunction

    task automatic head_check(input int i);
        check("head_valid", {31'h0, trace_valid}, 32'h1);
        check("head_pc", trace_pc, rec_pc(i));
        check("head_addr", trace_addr, rec_addr(i));
        check("head_data", trace_data, rec_data(i));
    endtask

    initial begin
        //           addr        wdata         be       pc            exp_rd        tv    tpc           taddr   tdata
        vecs[0]  = '{32'h0,    32'h0,        4'b0000, 32'h00400000, 32'h0,        1'b0, 32'h0,        32'h0,    32'h0};
        vecs[1]  = '{32'h2FFC, 32'h0,        4'b0000, 32'h00400004, 32'h0,        1'b0, 32'h0,        32'h0,    32'h0};
        vecs[2]  = '{32'h3000, 32'h0,        4'b0000, 32'h00400008, 32'h0,        1'b0, 32'h0,        32'h0,    32'h0};
        vecs[3]  = '{32'h10,   32'h12345678, 4'b1111, 32'h0040000C, 32'h0,        1'b1, 32'h0040000C, 32'h10,   32'h12345678};
        vecs[4]  = '{32'h10,   32'h0,        4'b0000, 32'h00400010, 32'h12345678, 1'b0, 32'h0,        32'h0,    32'h0};
        vecs[5]  = '{32'h12,   32'hABCDABCD, 4'b1100, 32'h00400014, 32'h12345678, 1'b1, 32'h00400014, 32'h10,   32'hABCD5678};
        vecs[6]  = '{32'h10,   32'h0,        4'b0000, 32'h00400018, 32'hABCD5678, 1'b0, 32'h0,        32'h0,    32'h0};
        vecs[7]  = '{32'h21,   32'hEEEEEEEE, 4'b0010, 32'h0040001C, 32'h0,        1'b1, 32'h0040001C, 32'h20,   32'h0000EE00};
        vecs[8]  = '{32'h20,   32'h0,        4'b0000, 32'h00400020, 32'h0000EE00, 1'b0, 32'h0,        32'h0,    32'h0};
        vecs[9]  = '{32'h2FFF, 32'hAABBCCDD, 4'b1000, 32'h00400024, 32'h0,        1'b1, 32'h00400024, 32'h2FFC, 32'hAA000000};
        vecs[10] = '{32'h2FFC, 32'h0,        4'b0000, 32'h00400028, 32'hAA000000, 1'b0, 32'h0,        32'h0,    32'h0};

        reset       = 1'b1;
        trace_ready = 1'b0;
        drive(32'h0, 32'h0, 4'b0000, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        check("rst_addr_err", {31'h0, addr_err}, 32'h0);
        check("rst_trace_valid", {31'h0, trace_valid}, 32'h0);
        check("rst_trace_overflow", {31'h0, trace_overflow}, 32'h0);
        check("rst_trace_pc", trace_pc, 32'h0);
        check("rst_trace_data", trace_data, 32'h0);

        trace_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].pc);
            #1;
            check($sformatf("v%0d_rdata", i), m_data_rdata, vecs[i].exp_rd);
            tick();
            check($sformatf("v%0d_addr_err", i), {31'h0, addr_err}, 32'h0);
`ifdef DM_TRACE_EN
            check($sformatf("v%0d_tvalid", i), {31'h0, trace_valid}, {31'h0, vecs[i].exp_tv});
            if (vecs[i].exp_tv) begin
                check($sformatf("v%0d_tpc", i), trace_pc, vecs[i].exp_tpc);
                check($sformatf("v%0d_taddr", i), trace_addr, vecs[i].exp_taddr);
                check($sformatf("v%0d_tdata", i), trace_data, vecs[i].exp_tdata);
            end
`else
            check($sformatf("v%0d_tvalid", i), {31'h0, trace_valid}, 32'h0);
            check($sformatf("v%0d_tdata", i), trace_data, 32'h0);
`endif
        end

        // Out-of-range store: flags addr_err, no memory change, no trace record.
        trace_ready = 1'b0;
        drive(32'h3000, 32'hDEADBEEF, 4'b1111, 32'h00400100);
        #1;
        check("oor_rdata", m_data_rdata, 32'h0);
        tick();
        check("oor_addr_err", {31'h0, addr_err}, 32'h1);
        check("oor_no_push", {31'h0, trace_valid}, 32'h0);
        read_check("oor_mem_0", 32'h0, 32'h0);
        read_check("oor_mem_10", 32'h10, 32'hABCD5678);
        tick();
        check("oor_sticky", {31'h0, addr_err}, 32'h1);

        // Reset wins over a store in the same cycle.
        reset = 1'b1;
        drive(32'h40, 32'hFFFFFFFF, 4'b1111, 32'h00400104);
        tick();
        reset = 1'b0;
        check("rst2_addr_err", {31'h0, addr_err}, 32'h0);
        check("rst2_trace_valid", {31'h0, trace_valid}, 32'h0);
        read_check("rst2_mem_40", 32'h40, 32'h0);
        read_check("rst2_mem_10", 32'h10, 32'h0);

`ifdef DM_TRACE_EN
        // Overflow: nine stores into an 8-deep queue with no consumer.
        trace_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(rec_addr(i), rec_data(i), 4'b1111, rec_pc(i));
            tick();
            check($sformatf("ovf_flag_%0d", i), {31'h0, trace_overflow}, (i == 8) ? 32'h1 : 32'h0);
        end
        drive(32'h0, 32'h0, 4'b0000, 32'h0);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            head_check(i);
            tick();
        end
        check("ovf_drained", {31'h0, trace_valid}, 32'h0);
        check("ovf_sticky", {31'h0, trace_overflow}, 32'h1);

        // Full queue: push and pop in the same cycle keeps occupancy at 8.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(rec_addr(i), rec_data(i), 4'b1111, rec_pc(i));
            tick();
        end
        drive(rec_addr(8), rec_data(8), 4'b1111, rec_pc(8));
        trace_ready = 1'b1;
        head_check(0);
        tick();
        check("full_pp_overflow", {31'h0, trace_overflow}, 32'h0);
        drive(32'h0, 32'h0, 4'b0000, 32'h0);
        for (int i = 1; i < 9; i++) begin
            head_check(i);
            tick();
        end
        check("full_pp_drained", {31'h0, trace_valid}, 32'h0);
`else
        trace_ready = 1'b1;
        drive(32'h200, 32'h5A5A5A5A, 4'b1111, 32'h00400200);
        tick();
        check("notrace_valid", {31'h0, trace_valid}, 32'h0);
        check("notrace_overflow", {31'h0, trace_overflow}, 32'h0);
        check("notrace_pc", trace_pc, 32'h0);
        check("notrace_addr", trace_addr, 32'h0);
        read_check("notrace_mem_200", 32'h200, 32'h5A5A5A5A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the pipelined MIPS core: the target end of the core's `m_data_*` interface. Serves word reads combinationally and performs byte-enabled writes on the clock edge into a 3072-word store. An optional trace queue records every accepted store as `{pc, word address, merged word}` for the bench checker, using a valid/ready handshake. Sits beside the core in the top-level wrapper, in place of the testbench's behavioural memory.

## Interface
Parameters:
- `WORDS`, 3072: storage depth in 32-bit words; valid byte addresses are 0 to `WORDS*4-1`.
- `TRACE_DEPTH`, 8: trace queue entries; must be a power of two, at least 2.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `m_data_addr` in 32: byte address from the core's MEM stage.
- `m_data_wdata` in 32: store data, already lane-replicated by the core.
- `m_data_byteen` in 4: byte write enables; `4'b0000` means no write.
- `m_inst_addr` in 32: PC of the MEM-stage instruction, used for trace only.
- `m_data_rdata` out 32: read word at `m_data_addr[31:2]`.
- `trace_valid` out 1: the trace head entry is valid.
- `trace_ready` in 1: the consumer accepts the head entry.
- `trace_pc` out 32: PC of the head entry.
- `trace_addr` out 32: word-aligned address of the head entry.
- `trace_data` out 32: full word after the store was merged.
- `trace_overflow` out 1: sticky; a store record was dropped.
- `addr_err` out 1: sticky; a store targeted an out-of-range address.

## Operation
- Word index is `m_data_addr[31:2]`. The access is in range when the index is below `WORDS`.
- **Read path.** Fully combinational, no stall.
  - `m_data_rdata` is `mem[index]` when in range, otherwise 0.
  - The core does lane extraction for `lb`/`lh`; this block always returns the whole word.
- **Write path.** When `m_data_byteen != 0` and the address is in range:
  - At the clock edge, each byte lane `k` with `byteen[k]=1` takes `m_data_wdata[8k+7:8k]`.
  - Lanes with `byteen[k]=0` keep their contents.
- **Out-of-range store.** When `byteen != 0` and the address is out of range:
  - No memory change and no trace push.
  - `addr_err` is set the next cycle and stays set until reset.
  - Out-of-range reads never set `addr_err`.
- **Trace push.** Every in-range store pushes `{m_inst_addr, {m_data_addr[31:2],2'b00}, merged}`, where `merged` is the post-write word.
- **Trace pop.** Pop occurs when `trace_valid && trace_ready`.
- **Trace queue storage.**
  - Circular buffer with read and write pointers of `log2(TRACE_DEPTH)` bits that wrap modulo depth.
  - Occupancy counter of `log2(TRACE_DEPTH)+1` bits.
- **Push when full.**
  - Push while full with no pop in the same cycle: the record is dropped and `trace_overflow` is set.
  - Push while full with a pop in the same cycle: both happen and occupancy stays full.
- **Pop when empty.** Pop while empty is a no-op; `trace_ready` is ignored.
- **Simultaneous push and pop.** On a non-empty, non-full queue, occupancy is unchanged.

## Timing
- **Reset values.** Reset is sampled on the `clk` rising edge. It clears:
  - all `WORDS` memory words to 0;
  - the queue pointers and occupancy;
  - `trace_valid=0`, `trace_overflow=0`, `addr_err=0`;
  - `trace_pc`, `trace_addr` and `trace_data` to 0.
- **Reset outputs.** While reset is high, `m_data_rdata` still reflects the memory, which is all zeros after the first reset edge.
- **Reset mid-operation.** A store or push in the same cycle as reset is discarded; reset wins.
- **Read latency.** 0 cycles. `m_data_rdata` tracks `m_data_addr` combinationally.
- **Read during a write to the same word.** The pre-edge (old) value is returned. The new value is visible from the next cycle.
- **Store visibility.** A store at edge N is visible to a read in cycle N+1.
- **Trace latency.** A store at edge N gives `trace_valid=1`, with the head fields valid, in cycle N+1 when the queue was empty. The head is first-word-fall-through and the outputs are registered.
- **Handshake.**
  - `trace_valid` and the head fields hold steady until popped.
  - After a pop at edge N, the next entry, if any, is presented in cycle N+1 with no bubble.

## Configuration
- **`DM_TRACE_EN` defined.** The trace queue and its logic are compiled in, as described above.
- **`DM_TRACE_EN` undefined.** No queue storage is built.
  - `trace_valid`, `trace_pc`, `trace_addr`, `trace_data` and `trace_overflow` are tied to 0.
  - `trace_ready` is ignored.
  - Read, write and `addr_err` behaviour is unchanged.

## Test plan
- **Reset then read.** Apply reset; read addresses 0x0, 0x2FFC and 0x3000.
  - Required: `m_data_rdata=0` for all three.
  - Required: `addr_err=0` and `trace_valid=0`.
- **Full-word and halfword stores.**
  - Store `wdata=0x12345678`, `byteen=1111` at 0x10; read 0x10.
    - Required: 0x12345678 next cycle.
    - Required: trace head `{pc, 0x10, 0x12345678}`.
  - Then store `wdata=0xABCDABCD`, `byteen=1100` at 0x12.
    - Required: word 0x10 reads 0xABCD5678.
    - Required: `trace_data=0xABCD5678`, `trace_addr=0x10`.
- **Byte store.** Store `wdata=0xEEEEEEEE`, `byteen=0010` at 0x21 onto word 0x20 = 0x00000000.
  - Required: word 0x20 reads 0x0000EE00.
- **Out-of-range store.** Store `byteen=1111` at 0x3000.
  - Required: `addr_err=1` next cycle, no trace push, memory unchanged.
  - Apply reset. Required: `addr_err=0`.
- **Trace overflow.** Hold `trace_ready=0` and issue 9 stores with `TRACE_DEPTH=8`.
  - Required: `trace_overflow=1` after the 9th store.
  - Then pop 8 entries. Required: they return the first 8 records in order, then `trace_valid=0`.
- **Push and pop on a full queue.** With the queue full and `trace_ready=1`, store in the same cycle.
  - Required: no overflow, occupancy stays 8.
  - Required: the new record appears after the 7 older remaining entries.
